// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: MIPS opcodes, index width, counter width.
package reg_scoreboard_pkg;

    localparam int REG_IDX_W = 5;
    localparam int SB_CNT_W  = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/reg_scoreboard_if.sv
// ID-query / issue / retire / squash bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic [5:0]           opcode;
    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
    logic                 issue_valid;
    logic                 issue_regwrite;
    logic [REG_IDX_W-1:0] issue_dest;
    logic                 retire_valid;
    logic [REG_IDX_W-1:0] retire_dest;
    logic                 squash_valid;
    logic [REG_IDX_W-1:0] squash_dest;
    logic                 stall;
    logic                 sb_err;

    modport master (
        output opcode, rs, rt, issue_valid, issue_regwrite, issue_dest,
               retire_valid, retire_dest, squash_valid, squash_dest,
        input  stall, sb_err
    );

    modport slave (
        input  opcode, rs, rt, issue_valid, issue_regwrite, issue_dest,
               retire_valid, retire_dest, squash_valid, squash_dest,
        output stall, sb_err
    );

endinterface

// File: rtl/reg_scoreboard_src_use_decode.sv
// Opcode -> which source registers the ID-stage instruction actually reads.
module src_use_decode
    import reg_scoreboard_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic       o_use_rs,
    output logic       o_use_rt
);

    always_comb begin
        o_use_rs = 1'b0;
        o_use_rt = 1'b0;
        case (i_opcode)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: begin
                o_use_rs = 1'b1;
                o_use_rt = 1'b1;
            end
            OP_LW, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI: begin
                o_use_rs = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register in-flight counters driving the ID-stage stall.
// Optional SCB_WB_BYPASS_EN: a last-outstanding write retiring this cycle does not stall.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = SB_CNT_W
) (
    input  logic            clk,
    input  logic            rstn,
    reg_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NREG-1:0][CNT_W-1:0] r_cnt;
    logic [NREG-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [NREG-1:0]            w_err;
    logic                       r_err;
    logic                       w_use_rs, w_use_rt;
    logic                       w_pend_rs, w_pend_rt;
    logic                       w_byp_rs, w_byp_rt;
    logic                       w_stall, w_issue_eff;

    src_use_decode u_dec (
        .i_opcode (sb.opcode),
        .o_use_rs (w_use_rs),
        .o_use_rt (w_use_rt)
    );

    assign w_pend_rs = (sb.rs != '0) && (r_cnt[sb.rs] != '0);
    assign w_pend_rt = (sb.rt != '0) && (r_cnt[sb.rt] != '0);

`ifdef SCB_WB_BYPASS_EN
    // Write-first regfile: the final outstanding write lands in time for this read.
    assign w_byp_rs = sb.retire_valid && (sb.retire_dest == sb.rs) && (r_cnt[sb.rs] == CNT_ONE);
    assign w_byp_rt = sb.retire_valid && (sb.retire_dest == sb.rt) && (r_cnt[sb.rt] == CNT_ONE);
`else
    assign w_byp_rs = 1'b0;
    assign w_byp_rt = 1'b0;
`endif

    assign w_stall     = (w_use_rs && w_pend_rs && !w_byp_rs) ||
                         (w_use_rt && w_pend_rt && !w_byp_rt);
    assign w_issue_eff = sb.issue_valid && sb.issue_regwrite && !w_stall && (sb.issue_dest != '0);

    always_comb begin
        logic             inc;
        logic [1:0]       ndec;
        logic [CNT_W+1:0] cur, need;
        w_cnt_nxt = r_cnt;
        w_err     = '0;
        inc       = 1'b0;
        ndec      = '0;
        cur       = '0;
        need      = '0;
        for (int r = 1; r < NREG; r++) begin
            inc  = w_issue_eff && (sb.issue_dest == REG_IDX_W'(r));
            ndec = {1'b0, sb.retire_valid && (sb.retire_dest == REG_IDX_W'(r))} +
                   {1'b0, sb.squash_valid && (sb.squash_dest == REG_IDX_W'(r))};
            cur  = {2'b00, r_cnt[r]};
            if (inc && ndec == 2'd0) begin
                if (r_cnt[r] == CNT_MAX) w_err[r] = 1'b1;
                else                     w_cnt_nxt[r] = r_cnt[r] + CNT_ONE;
            end else if (ndec > {1'b0, inc}) begin
                // Net decrement of 1 or 2; saturate at zero rather than wrap.
                need = (CNT_W+2)'(ndec) - (CNT_W+2)'(inc);
                if (cur < need) begin
                    w_cnt_nxt[r] = '0;
                    w_err[r]     = 1'b1;
                end else begin
                    w_cnt_nxt[r] = CNT_W'(cur - need);
                end
            end
        end
        w_cnt_nxt[0] = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= r_err | (|w_err);
        end
    end

    assign sb.stall  = w_stall;
    assign sb.sb_err = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed checks of the register scoreboard: reset, RAW stall, same-cycle events, squash, decode, errors.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

`ifdef SCB_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    reg_scoreboard_if sbif ();

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sb   (sbif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int idx);
        return 32'(dut.r_cnt[idx]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sbif.opcode         = OP_J;
        sbif.rs             = '0;
        sbif.rt             = '0;
        sbif.issue_valid    = 1'b0;
        sbif.issue_regwrite = 1'b0;
        sbif.issue_dest     = '0;
        sbif.retire_valid   = 1'b0;
        sbif.retire_dest    = '0;
        sbif.squash_valid   = 1'b0;
        sbif.squash_dest    = '0;
    endtask

    task automatic issue(input logic [4:0] d);
        sbif.issue_valid    = 1'b1;
        sbif.issue_regwrite = 1'b1;
        sbif.issue_dest     = d;
    endtask

    task automatic retire(input logic [4:0] d);
        sbif.retire_valid = 1'b1;
        sbif.retire_dest  = d;
    endtask

    task automatic query(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
        sbif.opcode = op;
        sbif.rs     = s;
        sbif.rt     = t;
    endtask

    logic [5:0] dec_op  [6] = '{OP_LW, OP_SW, OP_J, OP_BNE, OP_ORI, OP_LUI};
    logic [4:0] dec_rs  [6] = '{5'd0,  5'd0,  5'd4, 5'd4,   5'd4,   5'd4};
    logic [4:0] dec_rt  [6] = '{5'd4,  5'd4,  5'd4, 5'd0,   5'd0,   5'd0};
    logic       dec_exp [6] = '{1'b0,  1'b1,  1'b0, 1'b1,   1'b1,   1'b0};

    initial begin
        // Reset held while an issue of r7 is presented
        idle();
        rstn = 1'b0;
        issue(5'd7);
        query(OP_RTYPE, 5'd7, 5'd0);
        repeat (2) tick();
        check("rst_stall", sbif.stall, 0);
        check("rst_err", sbif.sb_err, 0);
        check("rst_cnt7", cnt(7), 0);
        idle();
        query(OP_RTYPE, 5'd7, 5'd0);
        rstn = 1'b1;
        #1 check("post_rst_stall", sbif.stall, 0);
        tick();

        // RAW on r8
        idle();
        query(OP_ADDIU, 5'd0, 5'd0);
        issue(5'd8);
        tick();
        idle();
        query(OP_RTYPE, 5'd8, 5'd0);
        #1 check("raw_c1", sbif.stall, 1);
        tick();
        check("raw_c2", sbif.stall, 1);
        retire(5'd8);
        #1 check("raw_c3", sbif.stall, {31'd0, !BYP});
        tick();
        sbif.retire_valid = 1'b0;
        #1 check("raw_c4", sbif.stall, 0);
        check("raw_cnt8", cnt(8), 0);

        // Same-cycle issue+retire of r5, stalled issue, r0 issue
        idle();
        issue(5'd5);
        tick();
        idle();
        check("same_cnt5_a", cnt(5), 1);
        issue(5'd5);
        retire(5'd5);
        tick();
        idle();
        check("same_cnt5_b", cnt(5), 1);
        query(OP_RTYPE, 5'd5, 5'd0);
        #1 check("same_stall5", sbif.stall, 1);
        issue(5'd10);
        tick();
        idle();
        check("stalled_issue_cnt10", cnt(10), 0);
        issue(5'd0);
        tick();
        idle();
        check("r0_cnt", cnt(0), 0);
        query(OP_RTYPE, 5'd0, 5'd0);
        #1 check("r0_stall", sbif.stall, 0);
        retire(5'd5);
        tick();
        idle();
        check("same_cnt5_c", cnt(5), 0);

        // Squash of r9
        issue(5'd9);
        tick();
        idle();
        sbif.squash_valid = 1'b1;
        sbif.squash_dest  = 5'd9;
        query(OP_BEQ, 5'd0, 5'd9);
        #1 check("sq_pre_stall", sbif.stall, 1);
        tick();
        idle();
        check("sq_cnt9", cnt(9), 0);
        query(OP_BEQ, 5'd0, 5'd9);
        #1 check("sq_beq_stall", sbif.stall, 0);

        // Source-use decode with r4 pending
        idle();
        issue(5'd4);
        tick();
        idle();
        for (int i = 0; i < 6; i++) begin
            query(dec_op[i], dec_rs[i], dec_rt[i]);
            #1 check($sformatf("dec_%0d", i), sbif.stall, {31'd0, dec_exp[i]});
        end
        idle();
        retire(5'd4);
        tick();
        idle();

        // Counter saturation and underflow
        check("err_pre", sbif.sb_err, 0);
        for (int i = 0; i < 3; i++) begin
            issue(5'd3);
            tick();
        end
        idle();
        check("ovf_cnt3_a", cnt(3), 3);
        check("ovf_err_a", sbif.sb_err, 0);
        issue(5'd3);
        tick();
        idle();
        check("ovf_cnt3_b", cnt(3), 3);
        check("ovf_err_b", sbif.sb_err, 1);
        retire(5'd6);
        tick();
        idle();
        check("unf_cnt6", cnt(6), 0);
        check("unf_err", sbif.sb_err, 1);
        retire(5'd3);
        sbif.squash_valid = 1'b1;
        sbif.squash_dest  = 5'd3;
        tick();
        idle();
        check("dbl_dec_cnt3", cnt(3), 1);
        retire(5'd3);
        tick();
        idle();
        check("dec_cnt3", cnt(3), 0);
        check("err_sticky", sbif.sb_err, 1);
        rstn = 1'b0;
        #1 check("err_reset", sbif.sb_err, 0);
        rstn = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-pending scoreboard for the 5-stage MIPS pipeline; the write-side counterpart of the ID-stage stall logic.
- Producers mark destination registers busy when they issue from ID into EX, and clear them when they retire in WB or are squashed in EX.
- The ID stage queries rs/rt against this state; stall is raised when a needed source is still pending.
- Replaces per-stage destination comparisons with one counter per architectural register.

Parameters:
- NREG, 32, number of architectural registers; index width is 5.
- CNT_W, 2, width of each per-register in-flight counter; maximum count is 2^CNT_W-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- opcode  in  6  ID-stage instruction opcode.
- rs  in  5  ID-stage source register 1.
- rt  in  5  ID-stage source register 2.
- issue_valid  in  1  ID instruction advances to EX this cycle.
- issue_regwrite  in  1  issuing instruction writes a register.
- issue_dest  in  5  destination of the issuing instruction.
- retire_valid  in  1  WB stage writes the register file this cycle.
- retire_dest  in  5  WB destination.
- squash_valid  in  1  EX instruction is flushed this cycle (branch redirect).
- squash_dest  in  5  destination of the squashed instruction; only meaningful if it had regwrite set.
- stall  out  1  hold PC and IF/ID, inject bubble into ID/EX.
- sb_err  out  1  sticky counter overflow/underflow flag.

Behaviour:
- State: cnt[r], CNT_W bits, r=1..NREG-1. cnt[0] is hardwired 0 and never pending.
- Async reset (rstn=0): all cnt=0, sb_err=0. stall therefore reads 0 during reset. Reset mid-operation discards all in-flight tracking.
- Source use is decoded from opcode by sub-module src_use_decode:
  - R-type, BEQ, BNE, SW: use rs and rt.
  - LW, SLTI, SLTIU, ORI, XORI, ANDI, ADDIU, LUI-free I-types: use rs only.
  - J, JAL and undefined opcodes: use neither.
- stall (combinational from registered state): (use_rs && rs!=0 && cnt[rs]!=0) || (use_rt && rt!=0 && cnt[rt]!=0).
- Effective issue: issue_eff = issue_valid && issue_regwrite && !stall && issue_dest!=0. An issue presented while stall=1 is ignored.
- Per-register net update at the clock edge: delta = +issue_eff − retire_hit − squash_hit, applied to each addressed register.
  - Events addressing the same register in one cycle sum. Example: issue and retire of r5 together leave cnt[5] unchanged.
  - Events to r0 are ignored.
- Increment at maximum count: cnt holds, sb_err set. Decrement at 0: cnt holds at 0, sb_err set. sb_err clears only on reset.
- Latency: an issue in cycle N is visible to stall in cycle N+1. A retire in cycle N clears in cycle N+1 (see optional feature).

Optional Feature:
- Macro: SCB_WB_BYPASS_EN.
- Defined: for stall evaluation only, a register with cnt==1 being retired in the same cycle (retire_valid && retire_dest==src) is treated as not pending. This matches a write-first register file and removes one stall cycle.
- Not defined: stall uses registered cnt only.
- The counter update rule is identical in both builds.

Decomposition:
- Shared package / GLOBAL defines: OP_* opcode constants (existing), REG_IDX_W=5, SB_CNT_W default.
- Sub-module src_use_decode: opcode -> use_rs, use_rt, purely combinational. Reusable by the forwarding unit.

Test Plan:
- Reset: hold rstn=0 with issue_valid=1 and dest 7 -> cnt all 0, stall=0, sb_err=0. After release, query rs=7 with R-type -> stall=0.
- RAW: cycle 0 issue addiu dest r8. Cycle 1 R-type rs=8 -> stall=1. Retire r8 in cycle 3 -> stall=0 in cycle 4 (cycle 3 with SCB_WB_BYPASS_EN).
- Same cycle: cnt[5]=1, then issue r5 plus retire r5 -> cnt[5] stays 1 and stall persists for rs=5. Issue r0 -> no stall, cnt[0] stays 0.
- Squash: issue r9, then squash r9 next cycle -> cnt[9]=0 and a BEQ with rt=9 does not stall.
- Use decode: LW with rt=4 while r4 pending -> stall=0. SW with rt=4 -> stall=1. J with rs=rt=4 -> stall=0.
- Errors: four issues of r3 with CNT_W=2 -> cnt[3]=3 and sb_err=1. Retire r6 at cnt 0 -> cnt stays 0, sb_err remains 1 until reset.
